// File: rtl/charge_pkg.sv
// Shared types and default sizing for the charge session controller.
package charge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ARMED    = 3'd1,
        ST_CHARGING = 3'd2,
        ST_PAUSED   = 3'd3,
        ST_DONE     = 3'd4
    } charge_state_t;

    localparam int CHARGE_WIDTH       = 12;
    localparam int CHARGE_WARN_THRESH = 30;
    localparam int CHARGE_PAUSE_LIMIT = 60;

endpackage

// File: rtl/charge_pause_timer.sv
// Counts time-base ticks while a session is paused and flags the tick that
// reaches the forfeit limit, so the session can end on that same edge.
module charge_pause_timer (
    input  logic       Clk,
    input  logic       nReset,
    input  logic       i_clear,
    input  logic       i_tick_en,
    input  logic [7:0] i_limit,
    output logic       o_expired
);

    logic [7:0] r_count;
    logic [8:0] w_count_inc;

    assign w_count_inc = {1'b0, r_count} + 9'd1;

    // Asserted on the tick that brings the count up to the limit.
    assign o_expired = i_tick_en && (w_count_inc >= {1'b0, i_limit});

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_count <= 8'd0;
        end else if (i_clear) begin
            r_count <= 8'd0;
        end else if (i_tick_en && !o_expired) begin
            r_count <= w_count_inc[7:0];
        end
    end

endmodule

// File: rtl/charge_session.sv
// Session controller: loads credited time, drains it per Tick while plugged in,
// drives the contactor and status flags. CHARGE_WARN_EN enables LowCredit.
module charge_session
    import charge_pkg::*;
#(
    parameter int WIDTH       = CHARGE_WIDTH,
    parameter int WARN_THRESH = CHARGE_WARN_THRESH,
    parameter int PAUSE_LIMIT = CHARGE_PAUSE_LIMIT
) (
    input  logic             Clk,
    input  logic             nReset,
    input  logic [WIDTH-1:0] PresentTime,
    input  logic             Load,
    input  logic             Plug,
    input  logic             Tick,
    output logic [WIDTH-1:0] Remaining,
    output logic             ChargeOn,
    output logic             Busy,
    output logic             Done,
    output logic             LowCredit
);

    if (PAUSE_LIMIT < 1 || PAUSE_LIMIT > 255 || WARN_THRESH < 0) begin : g_param_check
        $error("charge_session: PAUSE_LIMIT must be 1..255 and WARN_THRESH non-negative");
    end

    localparam logic [7:0] LIMIT = 8'(PAUSE_LIMIT);

    charge_state_t    r_state;
    logic [WIDTH-1:0] r_remaining;
    logic             r_charge_on;
    logic             r_busy;
    logic             r_done;

    charge_state_t    w_state_nxt;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH:0]   w_wide_sum;
    logic [WIDTH-1:0] w_sat_sum;
    logic [WIDTH-1:0] w_sum;
    logic             w_load_valid;
    logic             w_expired;
    logic             w_pause_clear;
    logic             w_pause_tick;

    // Top-up saturates at all-ones rather than wrapping.
    assign w_wide_sum   = {1'b0, r_remaining} + {1'b0, PresentTime};
    assign w_sat_sum    = w_wide_sum[WIDTH] ? '1 : w_wide_sum[WIDTH-1:0];
    assign w_sum        = Load ? w_sat_sum : r_remaining;
    assign w_load_valid = Load && (PresentTime != '0);

    assign w_pause_clear = (r_state != ST_PAUSED);
    assign w_pause_tick  = (r_state == ST_PAUSED) && Tick && !Plug;

    charge_pause_timer u_pause_timer (
        .Clk       (Clk),
        .nReset    (nReset),
        .i_clear   (w_pause_clear),
        .i_tick_en (w_pause_tick),
        .i_limit   (LIMIT),
        .o_expired (w_expired)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_remaining;
        case (r_state)
            ST_IDLE: begin
                if (w_load_valid) begin
                    w_rem_nxt   = PresentTime;
                    w_state_nxt = ST_ARMED;
                end
            end
            ST_ARMED: begin
                w_rem_nxt = w_sum;
                if (Plug) begin
                    w_state_nxt = ST_CHARGING;
                end
            end
            ST_CHARGING: begin
                // Unplug wins over a same-cycle Tick; a top-up still lands.
                if (!Plug) begin
                    w_rem_nxt   = w_sum;
                    w_state_nxt = ST_PAUSED;
                end else if (Tick) begin
                    w_rem_nxt = w_sum - WIDTH'(1);
                    if (w_sum == WIDTH'(1)) begin
                        w_state_nxt = ST_DONE;
                    end
                end else begin
                    w_rem_nxt = w_sum;
                end
            end
            ST_PAUSED: begin
                w_rem_nxt = w_sum;
                if (Plug) begin
                    w_state_nxt = ST_CHARGING;
                end else if (w_expired) begin
                    w_rem_nxt   = '0;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (w_load_valid) begin
                    w_rem_nxt   = PresentTime;
                    w_state_nxt = ST_ARMED;
                end else if (!Plug) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_rem_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

`ifdef CHARGE_WARN_EN
    logic r_low_credit;
    logic w_low_nxt;

    assign w_low_nxt = ((w_state_nxt == ST_CHARGING) || (w_state_nxt == ST_PAUSED)) &&
                       (w_rem_nxt != '0) && (w_rem_nxt <= WIDTH'(WARN_THRESH));
    assign LowCredit = r_low_credit;
`else
    assign LowCredit = 1'b0;
`endif

    // Outputs are registered from the next state so they match it after each edge.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_state      <= ST_IDLE;
            r_remaining  <= '0;
            r_charge_on  <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
`ifdef CHARGE_WARN_EN
            r_low_credit <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_remaining  <= w_rem_nxt;
            r_charge_on  <= (w_state_nxt == ST_CHARGING);
            r_busy       <= (w_state_nxt == ST_ARMED) || (w_state_nxt == ST_CHARGING) ||
                            (w_state_nxt == ST_PAUSED);
            r_done       <= (w_state_nxt == ST_DONE);
`ifdef CHARGE_WARN_EN
            r_low_credit <= w_low_nxt;
`endif
        end
    end

    assign Remaining = r_remaining;
    assign ChargeOn  = r_charge_on;
    assign Busy      = r_busy;
    assign Done      = r_done;

endmodule

// File: tb/tb_charge_session.sv
// Bench for charge_session: directed table, hand sequences and randomized
// traffic against a behavioural session model. Honours CHARGE_WARN_EN.
module tb_charge_session;

    localparam int W    = 12;
    localparam int THR  = 30;
    localparam int LIM  = 3;
    localparam int MAXV = 4095;

    localparam int P_IDLE   = 0;
    localparam int P_ARMED  = 1;
    localparam int P_CHARGE = 2;
    localparam int P_PAUSE  = 3;
    localparam int P_DONE   = 4;

    logic         Clk;
    logic         nReset;
    logic [W-1:0] PresentTime;
    logic         Load;
    logic         Plug;
    logic         Tick;
    logic [W-1:0] Remaining;
    logic         ChargeOn;
    logic         Busy;
    logic         Done;
    logic         LowCredit;

    int n_tests = 0;
    int n_fail  = 0;

    int m_phase;
    int m_rem;
    int m_pause;

    typedef struct {
        logic         ld;
        logic [W-1:0] pt;
        logic         pl;
        logic         tk;
        logic [W-1:0] rem;
        logic         on;
        logic         busy;
        logic         done;
    } vec_t;

    vec_t tbl[9];

    charge_session #(
        .WIDTH       (W),
        .WARN_THRESH (THR),
        .PAUSE_LIMIT (LIM)
    ) dut (
        .Clk         (Clk),
        .nReset      (nReset),
        .PresentTime (PresentTime),
        .Load        (Load),
        .Plug        (Plug),
        .Tick        (Tick),
        .Remaining   (Remaining),
        .ChargeOn    (ChargeOn),
        .Busy        (Busy),
        .Done        (Done),
        .LowCredit   (LowCredit)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int warn_expected();
`ifdef CHARGE_WARN_EN
        return ((m_phase == P_CHARGE || m_phase == P_PAUSE) && m_rem > 0 && m_rem <= THR) ? 1 : 0;
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        m_phase = P_IDLE;
        m_rem   = 0;
        m_pause = 0;
    endtask

    // Session rules applied to one sampled cycle of inputs.
    task automatic model_step(input bit ld, input int pt, input bit pl, input bit tk);
        int topped;
        topped = ld ? ((m_rem + pt > MAXV) ? MAXV : m_rem + pt) : m_rem;
        if (m_phase == P_IDLE) begin
            if (ld && pt != 0) begin
                m_rem   = pt;
                m_phase = P_ARMED;
            end
        end else if (m_phase == P_ARMED) begin
            m_rem = topped;
            if (pl) m_phase = P_CHARGE;
        end else if (m_phase == P_CHARGE) begin
            if (!pl) begin
                m_rem   = topped;
                m_pause = 0;
                m_phase = P_PAUSE;
            end else if (tk) begin
                m_rem = topped - 1;
                if (m_rem == 0) m_phase = P_DONE;
            end else begin
                m_rem = topped;
            end
        end else if (m_phase == P_PAUSE) begin
            m_rem = topped;
            if (pl) begin
                m_phase = P_CHARGE;
            end else if (tk) begin
                m_pause++;
                if (m_pause >= LIM) begin
                    m_rem   = 0;
                    m_phase = P_DONE;
                end
            end
        end else begin
            if (ld && pt != 0) begin
                m_rem   = pt;
                m_phase = P_ARMED;
            end else if (!pl) begin
                m_phase = P_IDLE;
            end
        end
    endtask

    task automatic compare_model(input string tag);
        check({tag, ".Remaining"}, int'(Remaining), m_rem);
        check({tag, ".ChargeOn"}, int'(ChargeOn), (m_phase == P_CHARGE) ? 1 : 0);
        check({tag, ".Busy"}, int'(Busy),
              (m_phase == P_ARMED || m_phase == P_CHARGE || m_phase == P_PAUSE) ? 1 : 0);
        check({tag, ".Done"}, int'(Done), (m_phase == P_DONE) ? 1 : 0);
        check({tag, ".LowCredit"}, int'(LowCredit), warn_expected());
    endtask

    task automatic apply(input string tag, input bit ld, input int pt, input bit pl, input bit tk);
        @(negedge Clk);
        Load        = ld;
        PresentTime = W'(pt);
        Plug        = pl;
        Tick        = tk;
        @(posedge Clk);
        #1;
        model_step(ld, pt, pl, tk);
        compare_model(tag);
        Load = 1'b0;
        Tick = 1'b0;
    endtask

    initial begin
        bit plug_lvl;
        int pt;
        int r;
        int exp_warn;

`ifdef CHARGE_WARN_EN
        exp_warn = 1;
`else
        exp_warn = 0;
`endif

        tbl[0] = '{1'b1, 12'd5, 1'b0, 1'b0, 12'd5, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{1'b0, 12'd0, 1'b1, 1'b0, 12'd5, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 12'd0, 1'b1, 1'b1, 12'd4, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 12'd0, 1'b1, 1'b1, 12'd3, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 12'd0, 1'b1, 1'b1, 12'd2, 1'b1, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 12'd0, 1'b1, 1'b1, 12'd1, 1'b1, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 12'd0, 1'b1, 1'b1, 12'd0, 1'b0, 1'b0, 1'b1};
        tbl[7] = '{1'b0, 12'd0, 1'b0, 1'b0, 12'd0, 1'b0, 1'b0, 1'b0};
        tbl[8] = '{1'b1, 12'd0, 1'b0, 1'b0, 12'd0, 1'b0, 1'b0, 1'b0};

        nReset      = 1'b0;
        Load        = 1'b0;
        PresentTime = '0;
        Plug        = 1'b0;
        Tick        = 1'b0;
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        compare_model("reset");
        @(negedge Clk);
        nReset = 1'b1;

        // Basic drain, unplug to idle, zero load ignored.
        for (int i = 0; i < 9; i++) begin
            apply($sformatf("vec%0d", i), tbl[i].ld, int'(tbl[i].pt), tbl[i].pl, tbl[i].tk);
            check($sformatf("vec%0d.rem", i), int'(Remaining), int'(tbl[i].rem));
            check($sformatf("vec%0d.on", i), int'(ChargeOn), int'(tbl[i].on));
            check($sformatf("vec%0d.busy", i), int'(Busy), int'(tbl[i].busy));
            check($sformatf("vec%0d.done", i), int'(Done), int'(tbl[i].done));
        end

        // Saturating top-up while charging.
        apply("sat_load", 1, 4090, 0, 0);
        apply("sat_plug", 0, 0, 1, 0);
        apply("sat_top", 1, 100, 1, 0);
        check("sat_value", int'(Remaining), MAXV);

        // Asynchronous reset mid-session, no clock edge needed.
        #2;
        nReset = 1'b0;
        #1;
        check("async_on", int'(ChargeOn), 0);
        check("async_rem", int'(Remaining), 0);
        check("async_busy", int'(Busy), 0);
        check("async_done", int'(Done), 0);
        check("async_low", int'(LowCredit), 0);
        model_reset();
        @(posedge Clk);
        #1;
        compare_model("async_hold");
        @(negedge Clk);
        nReset = 1'b1;
        apply("post_reset", 0, 0, 0, 0);
        check("post_reset_idle", int'(Busy), 0);

        // Same-cycle top-up and tick at Remaining=1.
        apply("lt_load", 1, 2, 0, 0);
        apply("lt_plug", 0, 0, 1, 0);
        apply("lt_tick", 0, 0, 1, 1);
        check("lt_before", int'(Remaining), 1);
        apply("lt_both", 1, 3, 1, 1);
        check("lt_rem", int'(Remaining), 3);
        check("lt_still_on", int'(ChargeOn), 1);

        // Pause, resume, then forfeit after the pause limit.
        apply("pz_top", 1, 7, 1, 0);
        apply("pz_unplug", 0, 0, 0, 0);
        apply("pz_t1", 0, 0, 0, 1);
        apply("pz_t2", 0, 0, 0, 1);
        apply("pz_replug", 0, 0, 1, 0);
        check("pz_resume_rem", int'(Remaining), 10);
        check("pz_resume_on", int'(ChargeOn), 1);
        apply("pz_unplug2", 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) apply($sformatf("pz_ft%0d", i), 0, 0, 0, 1);
        check("forfeit_rem", int'(Remaining), 0);
        check("forfeit_done", int'(Done), 1);
        apply("forfeit_idle", 0, 0, 0, 0);
        check("forfeit_idle_done", int'(Done), 0);

        // Low-credit warning crossing and release at the end.
        apply("wn_load", 1, 31, 0, 0);
        apply("wn_plug", 0, 0, 1, 0);
        check("wn_above", int'(LowCredit), 0);
        apply("wn_cross", 0, 0, 1, 1);
        check("wn_at_thresh", int'(LowCredit), exp_warn);
        for (int i = 0; i < 30; i++) apply($sformatf("wn_t%0d", i), 0, 0, 1, 1);
        check("wn_done", int'(Done), 1);
        check("wn_low_off", int'(LowCredit), 0);
        apply("wn_idle", 0, 0, 0, 0);

        // Randomized traffic against the model.
        plug_lvl = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 11) == 0) plug_lvl = ~plug_lvl;
            r = int'($urandom_range(0, 9));
            if (r == 0) pt = 0;
            else if (r == 1) pt = int'($urandom_range(0, MAXV));
            else pt = int'($urandom_range(1, 40));
            apply("rnd", ($urandom_range(0, 7) == 0), pt, plug_lvl, ($urandom_range(0, 1) == 1));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/charge_session.md
# charge_session

Consumer side of the coin-credit path. Takes the credited time word produced by the coin/counter chain, loads it into a session register, and drains it one unit per `Tick` while a vehicle is plugged in. Drives the charger contactor enable and the session status flags. Sits between the credit counter and the power stage / status display.

## Interface

Parameters:
- `WIDTH`, 12: width of credited and remaining time.
- `WARN_THRESH`, 30: low-credit warning threshold, in time units.
- `PAUSE_LIMIT`, 60: `Tick`s allowed unplugged mid-session before forfeit; 8-bit range, must be 1..255.

Ports:
- `Clk`  in  1: single clock; all state changes on rising edge.
- `nReset`  in  1: asynchronous, active-low reset.
- `PresentTime`  in  WIDTH: credited time from the credit counter.
- `Load`  in  1: one-cycle pulse; accept `PresentTime` as credit.
- `Plug`  in  1: vehicle connected, synchronous level.
- `Tick`  in  1: one-cycle time-base strobe, one time unit.
- `Remaining`  out  WIDTH: session time left.
- `ChargeOn`  out  1: contactor enable.
- `Busy`  out  1: session active (ARMED, CHARGING or PAUSED).
- `Done`  out  1: session ended (DONE state).
- `LowCredit`  out  1: low-credit warning; see Configuration.

## Operation

- FSM states: IDLE, ARMED, CHARGING, PAUSED, DONE.
- IDLE: `Load` with `PresentTime`≠0 → `Remaining`=`PresentTime`, go to ARMED. `Load` with zero is ignored.
- ARMED: `Plug`=1 → CHARGING. `Tick` is ignored.
- CHARGING: `ChargeOn`=1.
  - `Tick` decrements `Remaining`.
  - `Tick` with `Remaining`=1 and no top-up → `Remaining`=0, go to DONE.
  - `Plug`=0 → PAUSED, and the pause counter clears. Unplug has priority over a same-cycle `Tick`: no decrement.
- PAUSED: `ChargeOn`=0, `Remaining` frozen.
  - Each `Tick` increments the pause counter.
  - `Plug`=1 → CHARGING.
  - Pause counter reaches `PAUSE_LIMIT` → `Remaining`=0, go to DONE (forfeit).
- DONE: `Done`=1.
  - `Plug`=0 → IDLE.
  - Valid `Load` → ARMED. `Load` has priority over `Plug`=0.
- Top-up: `Load` in ARMED, CHARGING or PAUSED adds `PresentTime` to `Remaining`, saturating at 2^WIDTH−1.
  - `Load` and `Tick` in the same CHARGING cycle: `Remaining` = sat(`Remaining` + `PresentTime`) − 1. This stays in CHARGING whenever the result is nonzero.
- `Busy` = state ∈ {ARMED, CHARGING, PAUSED}.

## Timing

- Reset: state IDLE; `Remaining`=0; pause counter 0; all 1-bit outputs 0.
- Reset mid-session aborts immediately: `ChargeOn` drops asynchronously, and there is no DONE pulse.
- All outputs are registered. Their values reflect the state after each edge; there are no combinational paths from inputs.
- `Load` sampled at edge n → `Remaining` and `Busy` updated after edge n (latency 1).
- `Plug` rise sampled at edge n in ARMED → `ChargeOn`=1 after edge n.
- Final `Tick` at edge n → `ChargeOn`=0 and `Done`=1 after edge n.
- `Tick` and `Load` are single-cycle strobes. A held level counts once per cycle.

## Configuration

- `CHARGE_WARN_EN` defined: `LowCredit`=1 when state is CHARGING or PAUSED and 0<`Remaining`≤`WARN_THRESH`. It is registered and updates with `Remaining`.
- Not defined: `LowCredit` is tied 0, the port remains, and no comparator logic is built.

## Structure

- Package `charge_pkg`:
  - state enum `charge_state_t`;
  - default constants `CHARGE_WIDTH`=12, `CHARGE_WARN_THRESH`=30, `CHARGE_PAUSE_LIMIT`=60.
- Sub-module `charge_pause_timer`:
  - inputs: clear, tick-enable, limit;
  - output: expired flag;
  - owns the pause counter.
- FSM, saturating add and decrement stay in the top module.

## Test plan

- Reset, then `PresentTime`=5, `Load`, `Plug`=1, 5 `Tick`s → `ChargeOn` high for the drain, `Remaining` 5→0, `Done`=1 after the 5th tick. Unplug → IDLE.
- `PresentTime`=0 with `Load` in IDLE → no state change, `Busy`=0.
- Charging with `Remaining`=4090: `Load` with `PresentTime`=100 → `Remaining`=4095 (saturated). Same-cycle `Load`+`Tick` with `Remaining`=1 and `PresentTime`=3 → `Remaining`=3, still CHARGING.
- Unplug mid-session with `Remaining`=10, `PAUSE_LIMIT`=3: 2 `Tick`s then replug → resumes, `Remaining`=10. Unplug again plus 3 `Tick`s → DONE, `Remaining`=0.
- `nReset` low during CHARGING → `ChargeOn`=0 and all outputs 0 without waiting for a clock edge. After release, state is IDLE.
- With `CHARGE_WARN_EN`: `Remaining` 31→30 on a `Tick` → `LowCredit` rises on that edge, falls at DONE. Without the macro: `LowCredit` stays 0 throughout.
